// File: rtl/reg_ser_pkg.sv
// Shared types and constants for the REG serial transmitter.
package reg_ser_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_e;

endpackage : reg_ser_pkg

// File: rtl/reg_serializer_if.sv
// Word handshake plus REG serial strobe/data bundle.
// Optional parity output is present only when SER_PARITY_EN is defined.
interface reg_serializer_if
  import reg_ser_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             en;
  logic             shift;
  logic             D0;
  logic             busy;
  logic             done;
`ifdef SER_PARITY_EN
  logic             parity;
`endif

`ifdef SER_PARITY_EN
  modport master (output in_valid, in_data, en,
                  input  in_ready, shift, D0, busy, done, parity);
  modport slave  (input  in_valid, in_data, en,
                  output in_ready, shift, D0, busy, done, parity);
`else
  modport master (output in_valid, in_data, en,
                  input  in_ready, shift, D0, busy, done);
  modport slave  (input  in_valid, in_data, en,
                  output in_ready, shift, D0, busy, done);
`endif

endinterface : reg_serializer_if

// File: rtl/reg_serializer.sv
// Parallel-to-serial transmitter feeding the REG shift/D0 inputs, MSB first.
// WIDTH legal range is 2..32. Optional feature macro: SER_PARITY_EN adds a
// parity output holding the XOR-reduce of the last accepted word.
module reg_serializer
  import reg_ser_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              resetn,
  reg_serializer_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  ser_state_e       state_q;
  ser_state_e       state_d;
  logic [WIDTH-1:0] sreg_q;
  logic [CNT_W-1:0] cnt_q;

  logic accept;
  logic step;

  assign accept = (state_q == IDLE)  && bus.in_valid;
  assign step   = (state_q == SHIFT) && bus.en;

  // State register; reset aborts any word in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = SHIFT;
      SHIFT:   if (bus.en && (cnt_q == LAST_CNT)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; shift follows en combinationally while a word is in flight.
  always_comb begin
    bus.in_ready = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.shift    = 1'b0;
    bus.D0       = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
      end
      SHIFT: begin
        bus.busy  = 1'b1;
        bus.shift = bus.en;
        bus.D0    = sreg_q[WIDTH-1];
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: begin
        bus.in_ready = 1'b0;
      end
    endcase
  end

  // Shifter and bit counter; zero fill leaves sreg clear once the word is out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      sreg_q <= bus.in_data;
      cnt_q  <= '0;
    end else if (step) begin
      sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
      cnt_q  <= CNT_W'(cnt_q + 1'b1);
    end
  end

`ifdef SER_PARITY_EN
  logic parity_q;

  // Even-parity of the accepted word, held until the next accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^bus.in_data;
    end
  end

  assign bus.parity = parity_q;
`endif

endmodule : reg_serializer

// File: tb/tb_reg_serializer.sv
// Self-checking bench for reg_serializer with a behavioural REG receiver.
// Build with SER_PARITY_EN defined to also check the parity output.
module tb_reg_serializer;
  import reg_ser_pkg::*;

  localparam int unsigned W = DEFAULT_WIDTH;

  logic clk = 1'b1;
  logic resetn = 1'b0;

  reg_serializer_if #(.WIDTH(W)) bus();

  reg_serializer #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Receiving REG: shifts left with D0 into bit 0; parallel load tied off.
  logic [W-1:0] reg_q;
  logic         reg_load;
  assign reg_load = 1'b0;
  always_ff @(posedge clk) begin
    if (reg_load) reg_q <= '0;
    else if (bus.shift) reg_q <= {reg_q[W-2:0], bus.D0};
  end

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: bits still to send, done pending, current word.
  int           m_left = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_word = '0;
  int           m_shifts = 0;
  int           m_stalls = 0;
  int           low_cnt = 0;
  int           n_done = 0;
  bit           accepted = 1'b0;

  logic [W-1:0] pend[$];
  int en_mode = 0;
  bit hold_valid = 1'b0;
  bit gap_rand = 1'b0;
  int stalled = 0;
  localparam int STALL_AT = 3;
  localparam int STALL_LEN = 3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check the current cycle against the model, then advance the model past the next edge.
  task automatic tick();
    bit in_flight;
    @(negedge clk);
    in_flight = (m_left > 0);
    chk("in_ready", 32'(bus.in_ready), 32'(!in_flight && !m_done));
    chk("busy",     32'(bus.busy),     32'(in_flight || m_done));
    chk("done",     32'(bus.done),     32'(m_done));
    chk("shift",    32'(bus.shift),    32'(in_flight && bus.en));
    chk("D0",       32'(bus.D0),       in_flight ? 32'(m_word[m_left-1]) : 32'd0);
    if (bus.shift) m_shifts++;
    if (!bus.in_ready) low_cnt++;
    accepted = 1'b0;
    if (m_done) begin
      chk("reg_q",       32'(reg_q),    32'(m_word));
      chk("shift_count", 32'(m_shifts), 32'(W));
      chk("ready_low",   32'(low_cnt),  32'(W + 1 + m_stalls));
`ifdef SER_PARITY_EN
      chk("parity", 32'(bus.parity), 32'($countones(m_word) % 2));
`endif
      n_done++;
      m_done = 1'b0;
    end else if (in_flight) begin
      if (bus.en) begin
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end else begin
        m_stalls++;
      end
    end else if (bus.in_valid) begin
      m_word   = bus.in_data;
      m_left   = W;
      m_shifts = 0;
      m_stalls = 0;
      low_cnt  = 0;
      stalled  = 0;
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of stimulus from the pending-word queue, then tick.
  task automatic step();
    case (en_mode)
      1: bus.en = ($urandom_range(0, 3) != 0);
      2: begin
        if (m_left > 0 && (W - m_left) == STALL_AT && stalled < STALL_LEN) begin
          bus.en = 1'b0;
          stalled++;
        end else begin
          bus.en = 1'b1;
        end
      end
      default: bus.en = 1'b1;
    endcase
    if (!bus.in_valid && pend.size() > 0 && (!gap_rand || $urandom_range(0, 2) == 0)) begin
      bus.in_valid = 1'b1;
      bus.in_data  = pend[0];
    end
    tick();
    if (accepted) begin
      void'(pend.pop_front());
      if (hold_valid && pend.size() > 0) begin
        bus.in_data = pend[0];
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom);
      end
    end else if (!bus.in_valid) begin
      bus.in_data = W'($urandom);
    end
  endtask

  // Run until all queued words are out and the model is idle.
  task automatic run(input int max_cycles);
    int cyc = 0;
    while ((pend.size() > 0 || m_left > 0 || m_done || bus.in_valid) && cyc < max_cycles) begin
      step();
      cyc++;
    end
    if (cyc >= max_cycles) chk("timeout", 32'd1, 32'd0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    #2 resetn = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("rst_shift", 32'(bus.shift),    32'd0);
    chk("rst_D0",    32'(bus.D0),       32'd0);
    chk("rst_busy",  32'(bus.busy),     32'd0);
    chk("rst_done",  32'(bus.done),     32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    m_left = 0;
    m_done = 1'b0;
    pend.delete();
    @(negedge clk);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    int n_before;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.en       = 1'b1;

    // Reset held 25 ns, then idle for 5 cycles.
    #12;
    chk("reset_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_shift", 32'(bus.shift),    32'd0);
    chk("reset_D0",    32'(bus.D0),       32'd0);
    chk("reset_busy",  32'(bus.busy),     32'd0);
    chk("reset_done",  32'(bus.done),     32'd0);
    #13 resetn = 1'b1;
    @(posedge clk);
    #1;
    repeat (5) step();

    // Single word, en high.
    n_before = n_done;
    pend.push_back(8'b11101011);
    run(40);
    chk("single_done_count", 32'(n_done - n_before), 32'd1);

    // Stall after 3rd bit for 3 cycles.
    en_mode = 2;
    pend.push_back(8'b01011001);
    run(40);
    en_mode = 0;

    // Back-to-back with valid held high.
    hold_valid = 1'b1;
    n_before = n_done;
    pend.push_back(8'hA5);
    pend.push_back(8'h3C);
    run(60);
    chk("b2b_done_count", 32'(n_done - n_before), 32'd2);
    hold_valid = 1'b0;

    // Mid-word reset after 4 bits of 0xFF.
    n_before = n_done;
    pend.push_back(8'hFF);
    guard = 0;
    while (!(m_left == W - 4) && guard < 40) begin
      step();
      guard++;
    end
    if (guard >= 40) chk("timeout_midword", 32'd1, 32'd0);
    async_reset();
    repeat (3) step();
    chk("abort_no_done", 32'(n_done - n_before), 32'd0);
    pend.push_back(8'h81);
    run(40);
    chk("after_abort_done", 32'(n_done - n_before), 32'd1);

    // Parity-relevant words.
    pend.push_back(8'b11101011);
    pend.push_back(8'h81);
    pend.push_back(8'h01);
    run(80);

    // Randomized words, gaps, en and hold.
    en_mode  = 1;
    gap_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      hold_valid = ($urandom_range(0, 1) == 1);
      pend.push_back(W'($urandom));
      if ($urandom_range(0, 1) == 1) pend.push_back(W'($urandom));
      run(400);
    end
    en_mode = 0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_reg_serializer
